jtag_axi_req_buffer: RTL and testbench

JTAG_AXI_REQ_BUFFER -- requirements
Module: jtag_axi_req_buffer

---
 rtl/jtag_pkg.sv | 15 +
 rtl/jtag_axi_req_buffer.sv | 88 ++++++++
 tb/tb_jtag_axi_req_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared JTAG-to-AXI types and widths
package jtag_pkg;

  localparam int AFIFO_DEPTH = 4;
  localparam int SLOTS_W     = $clog2(AFIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        write;
    logic [2:0]  size;
  } s_axi_jtag_info_t;

endpackage

// File: rtl/jtag_axi_req_buffer.sv
// rtl/jtag_axi_req_buffer.sv - first-word-fall-through request FIFO between JTAG data registers and AXI master
module jtag_axi_req_buffer
  import jtag_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 tck,
  input  logic                 trstn,
  input  logic                 req_new_i,
  input  s_axi_jtag_info_t     axi_info_i,
  input  logic                 clear_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output s_axi_jtag_info_t     req_info_o,
  output logic [SLOTS_W-1:0]   fifo_slots_o,
  output logic                 overflow_o,
  output logic [7:0]           req_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  s_axi_jtag_info_t     r_mem [FIFO_DEPTH];
  logic [PTR_W:0]       r_wr_ptr;
  logic [PTR_W:0]       r_rd_ptr;
  logic [SLOTS_W-1:0]   r_slots;
  logic                 r_overflow;
  logic [7:0]           r_req_cnt;

  logic [PTR_W:0]       w_count;
  logic [PTR_W:0]       w_count_nxt;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop       = !w_empty && req_ready_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign w_push      = req_new_i && (!w_full || w_pop);
  assign w_drop      = req_new_i && !w_push;
  assign w_count_nxt = w_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

  always_ff @(posedge tck) begin
    if (w_push && !clear_i) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= axi_info_i;
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_slots    <= SLOTS_W'(FIFO_DEPTH);
      r_overflow <= 1'b0;
      r_req_cnt  <= 8'd0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_slots    <= SLOTS_W'(FIFO_DEPTH);
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_req_cnt <= r_req_cnt + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_slots <= SLOTS_W'(FIFO_DEPTH) - SLOTS_W'(w_count_nxt);
    end
  end

  // Storage is not reset; gating the head on empty keeps stale entries invisible.
  assign req_valid_o  = !w_empty;
  assign req_info_o   = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  assign fifo_slots_o = r_slots;
  assign overflow_o   = r_overflow;
  assign req_cnt_o    = r_req_cnt;

endmodule

// File: tb/tb_jtag_axi_req_buffer.sv
// tb/tb_jtag_axi_req_buffer.sv - directed scoreboard bench for jtag_axi_req_buffer
module tb_jtag_axi_req_buffer;
  import jtag_pkg::*;

  localparam int D = 4;

  logic                tck;
  logic                trstn;
  logic                req_new_i;
  s_axi_jtag_info_t    axi_info_i;
  logic                clear_i;
  logic                req_valid_o;
  logic                req_ready_i;
  s_axi_jtag_info_t    req_info_o;
  logic [SLOTS_W-1:0]  fifo_slots_o;
  logic                overflow_o;
  logic [7:0]          req_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  s_axi_jtag_info_t m_q[$];
  logic             m_ovf;
  logic [7:0]       m_cnt;

  jtag_axi_req_buffer #(.FIFO_DEPTH(D)) dut (
    .tck          (tck),
    .trstn        (trstn),
    .req_new_i    (req_new_i),
    .axi_info_i   (axi_info_i),
    .clear_i      (clear_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_info_o   (req_info_o),
    .fifo_slots_o (fifo_slots_o),
    .overflow_o   (overflow_o),
    .req_cnt_o    (req_cnt_o)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic s_axi_jtag_info_t mk(input logic [31:0] a);
    s_axi_jtag_info_t t;
    t.addr  = a;
    t.data  = $urandom;
    t.strb  = 4'($urandom_range(0, 15));
    t.write = 1'($urandom_range(0, 1));
    t.size  = 3'd2;
    return t;
  endfunction

  // Advance one edge: compare popped head, update the reference queue, sample at +1.
  task automatic cycle();
    bit pop;
    bit push;
    if (req_ready_i && m_q.size() > 0 && !clear_i)
      chk("pop_data", 96'(req_info_o), 96'(m_q[0]));
    if (clear_i) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = req_ready_i && (m_q.size() > 0);
      push = req_new_i && ((m_q.size() < D) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(axi_info_i);
        m_cnt = m_cnt + 8'd1;
      end
      if (req_new_i && !push) m_ovf = 1'b1;
    end
    @(posedge tck);
    #1;
  endtask

  task automatic check_state(input string tag);
    s_axi_jtag_info_t head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    chk({tag, ".valid"}, 96'(req_valid_o), 96'(m_q.size() > 0));
    chk({tag, ".info"},  96'(req_info_o),  96'(head));
    chk({tag, ".slots"}, 96'(fifo_slots_o), 96'(D - m_q.size()));
    chk({tag, ".ovf"},   96'(overflow_o),  96'(m_ovf));
    chk({tag, ".cnt"},   96'(req_cnt_o),   96'(m_cnt));
  endtask

  task automatic push_req(input logic [31:0] a, input logic rdy);
    req_new_i   = 1'b1;
    axi_info_i  = mk(a);
    req_ready_i = rdy;
    cycle();
    req_new_i   = 1'b0;
    req_ready_i = 1'b0;
  endtask

  task automatic drain();
    req_ready_i = 1'b1;
    for (int i = 0; i < D + 1; i++) cycle();
    req_ready_i = 1'b0;
  endtask

  initial begin
    s_axi_jtag_info_t held;
    logic [7:0]       cnt_before;
    trstn = 1'b0; req_new_i = 1'b0; axi_info_i = '0; clear_i = 1'b0; req_ready_i = 1'b0;
    m_ovf = 1'b0; m_cnt = 8'd0;
    #12;
    check_state("reset");
    chk("reset.slots_abs", 96'(fifo_slots_o), 96'(4));
    trstn = 1'b1;
    @(posedge tck); #1;

    // Single request
    push_req(32'h1000, 1'b0);
    check_state("single");
    chk("single.addr", 96'(req_info_o.addr), 96'(32'h1000));
    chk("single.slots_abs", 96'(fifo_slots_o), 96'(3));
    chk("single.cnt_abs", 96'(req_cnt_o), 96'(1));
    drain();
    check_state("single_drained");

    // Fill and overflow
    cnt_before = m_cnt;
    for (int i = 0; i < 5; i++) push_req(32'hA000 + 32'(i), 1'b0);
    check_state("fill");
    chk("fill.slots_abs", 96'(fifo_slots_o), 96'(0));
    chk("fill.ovf_abs", 96'(overflow_o), 96'(1));
    chk("fill.cnt_delta", 96'(req_cnt_o - cnt_before), 96'(4));
    drain();
    check_state("fill_drained");

    // Push and pop on the same edge while full
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    for (int i = 0; i < D; i++) push_req(32'hB000 + 32'(i), 1'b0);
    push_req(32'hB0FF, 1'b1);
    check_state("full_pushpop");
    chk("full_pushpop.slots_abs", 96'(fifo_slots_o), 96'(0));
    chk("full_pushpop.ovf_abs", 96'(overflow_o), 96'(0));
    drain();
    check_state("full_drained");

    // Backpressure: ready toggles every cycle
    for (int i = 0; i < 8; i++) begin
      req_new_i   = 1'b1;
      axi_info_i  = mk(32'hC000 + 32'(i));
      req_ready_i = i[0];
      held = (m_q.size() > 0) ? m_q[0] : '0;
      if (!req_ready_i && m_q.size() > 0) begin
        cycle();
        chk("stall_hold", 96'(req_info_o), 96'(held));
      end else begin
        cycle();
      end
    end
    req_new_i = 1'b0; req_ready_i = 1'b0;
    check_state("backpressure");
    drain();
    check_state("bp_drained");

    // Clear priority over push with overflow set
    for (int i = 0; i < D + 1; i++) push_req(32'hD000 + 32'(i), 1'b0);
    req_ready_i = 1'b1; cycle(); req_ready_i = 1'b0;
    check_state("pre_clear");
    cnt_before  = m_cnt;
    clear_i     = 1'b1;
    req_new_i   = 1'b1;
    axi_info_i  = mk(32'hD0FF);
    cycle();
    clear_i = 1'b0; req_new_i = 1'b0;
    check_state("clear");
    chk("clear.slots_abs", 96'(fifo_slots_o), 96'(4));
    chk("clear.cnt_same", 96'(req_cnt_o), 96'(cnt_before));

    // Reset between edges with two entries stored
    push_req(32'hE000, 1'b0);
    push_req(32'hE001, 1'b0);
    #2 trstn = 1'b0;
    m_q.delete(); m_ovf = 1'b0; m_cnt = 8'd0;
    #1;
    check_state("async_reset");
    #1 trstn = 1'b1;
    @(posedge tck); #1;
    push_req(32'hE0F0, 1'b0);
    check_state("post_reset");
    chk("post_reset.addr", 96'(req_info_o.addr), 96'(32'hE0F0));
    chk("post_reset.slots_abs", 96'(fifo_slots_o), 96'(3));
    drain();
    check_state("post_reset_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
